// File: rtl/board_ctl.sv
// Chess board controller: 64x4 board store with a registered draw-side read port,
// mouse click decoding and a select/move FSM that rewrites the board one entry per cycle.
module board_ctl #(
    parameter int BOARD_X0 = 256,
    parameter int BOARD_Y0 = 128,
    parameter int SQ_LOG2  = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        board_reset,
    input  logic [5:0]  figure_xy,
    output logic [3:0]  figure_code,
    output logic        sel_valid,
    output logic [5:0]  sel_xy,
    output logic        init_done,
    output logic [7:0]  move_cnt
);

    localparam logic [12:0] X_LO = 13'(BOARD_X0);
    localparam logic [12:0] X_HI = 13'(BOARD_X0 + (8 << SQ_LOG2));
    localparam logic [12:0] Y_LO = 13'(BOARD_Y0);
    localparam logic [12:0] Y_HI = 13'(BOARD_Y0 + (8 << SQ_LOG2));

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CHECK,
        S_SELECTED,
        S_WR_DST,
        S_WR_SRC
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  board [64];
    logic [5:0]  init_cnt;
    logic [5:0]  press_xy;
    logic        prev_left;

    logic [12:0] x_w, y_w, dx, dy;
    logic        press, in_board;
    logic [5:0]  click_xy;

    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        latch_press, set_sel, clr_sel, inc_move, init_fin;

    // Start position: row 0 black back rank, row 1 black pawns, row 6/7 white.
    function automatic logic [3:0] start_code(input logic [5:0] a);
        logic [3:0] back;
        case (a[2:0])
            3'd0, 3'd7: back = 4'd4;
            3'd1, 3'd6: back = 4'd2;
            3'd2, 3'd5: back = 4'd3;
            3'd3:       back = 4'd5;
            default:    back = 4'd6;
        endcase
        case (a[5:3])
            3'd0:    start_code = back + 4'd8;
            3'd1:    start_code = 4'd9;
            3'd6:    start_code = 4'd1;
            3'd7:    start_code = back;
            default: start_code = 4'd0;
        endcase
    endfunction

    assign x_w      = {1'b0, xpos};
    assign y_w      = {1'b0, ypos};
    assign dx       = x_w - X_LO;
    assign dy       = y_w - Y_LO;
    assign in_board = (x_w >= X_LO) && (x_w < X_HI) && (y_w >= Y_LO) && (y_w < Y_HI);
    assign click_xy = {3'(dy >> SQ_LOG2), 3'(dx >> SQ_LOG2)};
    assign press    = mouse_left && !prev_left;

    always_comb begin
        state_nxt   = state;
        wr_en       = 1'b0;
        wr_addr     = init_cnt;
        wr_data     = 4'd0;
        latch_press = 1'b0;
        set_sel     = 1'b0;
        clr_sel     = 1'b0;
        inc_move    = 1'b0;
        init_fin    = 1'b0;
        if (board_reset) begin
            state_nxt = S_INIT;
        end else begin
            case (state)
                S_INIT: begin
                    wr_en   = 1'b1;
                    wr_addr = init_cnt;
                    wr_data = start_code(init_cnt);
                    if (init_cnt == 6'd63) begin
                        init_fin  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (press && in_board) begin
                        latch_press = 1'b1;
                        state_nxt   = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (board[press_xy] != 4'd0) begin
                        set_sel   = 1'b1;
                        state_nxt = S_SELECTED;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_SELECTED: begin
                    if (press && in_board) begin
                        if (click_xy == sel_xy) begin
                            clr_sel   = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            latch_press = 1'b1;
                            state_nxt   = S_WR_DST;
                        end
                    end
                end
                S_WR_DST: begin
                    wr_en     = 1'b1;
                    wr_addr   = press_xy;
                    wr_data   = board[sel_xy];
                    state_nxt = S_WR_SRC;
                end
                S_WR_SRC: begin
                    wr_en     = 1'b1;
                    wr_addr   = sel_xy;
                    wr_data   = 4'd0;
                    clr_sel   = 1'b1;
                    inc_move  = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_INIT;
            init_cnt    <= 6'd0;
            init_done   <= 1'b0;
            sel_valid   <= 1'b0;
            sel_xy      <= 6'd0;
            move_cnt    <= 8'd0;
            press_xy    <= 6'd0;
            figure_code <= 4'd0;
            prev_left   <= 1'b1;
        end else begin
            state       <= state_nxt;
            prev_left   <= mouse_left;
            figure_code <= board[figure_xy];
            if (board_reset) begin
                init_cnt  <= 6'd0;
                init_done <= 1'b0;
                sel_valid <= 1'b0;
                move_cnt  <= 8'd0;
            end else begin
                if (state == S_INIT) init_cnt <= init_cnt + 6'd1;
                if (init_fin) init_done <= 1'b1;
                if (latch_press) press_xy <= click_xy;
                if (set_sel) begin
                    sel_valid <= 1'b1;
                    sel_xy    <= press_xy;
                end
                if (clr_sel) sel_valid <= 1'b0;
                if (inc_move) move_cnt <= move_cnt + 8'd1;
            end
        end
    end

    // Write port; the registered read above sees pre-write content on address collision.
    always_ff @(posedge clk) begin
        if (wr_en) board[wr_addr] <= wr_data;
    end

endmodule

// File: tb/tb_board_ctl.sv
// Randomised bench for board_ctl: a move-level board model feeds a read scoreboard,
// plus directed checks of selection, move counting, click bounds and board_reset.
module tb_board_ctl;

    localparam int TX0 = 256;
    localparam int TY0 = 128;
    localparam int SQ  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        mouse_left;
    logic [11:0] xpos, ypos;
    logic        board_reset;
    logic [5:0]  figure_xy;
    logic [3:0]  figure_code;
    logic        sel_valid;
    logic [5:0]  sel_xy;
    logic        init_done;
    logic [7:0]  move_cnt;

    board_ctl dut (
        .clk(clk), .rst(rst), .mouse_left(mouse_left), .xpos(xpos), .ypos(ypos),
        .board_reset(board_reset), .figure_xy(figure_xy), .figure_code(figure_code),
        .sel_valid(sel_valid), .sel_xy(sel_xy), .init_done(init_done), .move_cnt(move_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        int         addr;
        logic [3:0] d;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         busy_until = -1;
    bit         check_en = 0;
    bit         sweep = 0;
    logic [3:0] mboard [64];
    bit         msel = 0;
    int         msq = 0;
    int         mcnt = 0;
    wr_t        pend [$];
    logic [3:0] expq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] start_code(input int a);
        int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
        int row = a / 8;
        int col = a % 8;
        if (row == 0) return 4'(back[col] + 8);
        if (row == 1) return 4'd9;
        if (row == 6) return 4'd1;
        if (row == 7) return 4'(back[col]);
        return 4'd0;
    endfunction

    function automatic void model_reset();
        for (int a = 0; a < 64; a++) mboard[a] = start_code(a);
        msel = 0;
        mcnt = 0;
        busy_until = -1;
        pend.delete();
    endfunction

    // A press at edge p: selects, deselects, or moves (dst then src rewritten on the next two edges).
    function automatic void model_press(input int x, input int y, input int p);
        int sq;
        if (p <= busy_until) return;
        if (x < TX0 || x >= TX0 + 8 * SQ || y < TY0 || y >= TY0 + 8 * SQ) return;
        sq = ((y - TY0) / SQ) * 8 + (x - TX0) / SQ;
        if (!msel) begin
            if (mboard[sq] != 4'd0) begin
                msel = 1;
                msq  = sq;
            end
        end else if (sq == msq) begin
            msel = 0;
        end else begin
            pend.push_back('{p + 1, sq, mboard[msq]});
            pend.push_back('{p + 2, msq, 4'd0});
            msel = 0;
            mcnt = (mcnt + 1) % 256;
            busy_until = p + 2;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        if (check_en) expq.push_back(mboard[figure_xy]);
        while (pend.size() > 0 && pend[0].due == cyc) begin
            mboard[pend[0].addr] = pend[0].d;
            void'(pend.pop_front());
        end
        #1;
        figure_xy = sweep ? figure_xy + 6'd1 : 6'($urandom);
    endtask

    function automatic int px(input int c);
        return TX0 + c * SQ + int'($urandom_range(0, SQ - 1));
    endfunction

    function automatic int py(input int r);
        return TY0 + r * SQ + int'($urandom_range(0, SQ - 1));
    endfunction

    task automatic click(input int x, input int y, input int gap);
        xpos = 12'(x);
        ypos = 12'(y);
        mouse_left = 1'b1;
        step();
        mouse_left = 1'b0;
        model_press(x, y, cyc);
        repeat (gap) step();
    endtask

    task automatic chk_state(input string nm);
        chk({nm, ".sel_valid"}, sel_valid, msel);
        chk({nm, ".move_cnt"}, move_cnt, mcnt);
        if (msel) chk({nm, ".sel_xy"}, sel_xy, msq);
    endtask

    task automatic wait_init(input string nm);
        int n = 0;
        while (!init_done && n < 200) begin
            step();
            n++;
        end
        chk({nm, ".init_timeout"}, init_done, 1);
    endtask

    always @(negedge clk) begin
        if (expq.size() != 0) chk("figure_code", figure_code, expq.pop_front());
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b0;
        mouse_left = 1'b1;
        xpos = 12'(TX0 + 4 * SQ + 5);
        ypos = 12'(TY0 + 6 * SQ + 5);
        board_reset = 1'b0;
        figure_xy = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.init_done", init_done, 0);
        chk("rst.sel_valid", sel_valid, 0);
        chk("rst.sel_xy", sel_xy, 0);
        chk("rst.move_cnt", move_cnt, 0);
        chk("rst.figure_code", figure_code, 0);

        // Button held through reset and 100 cycles must not select anything.
        @(negedge clk) rst = 1'b1;
        n = 0;
        while (!init_done && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n < 64 || n > 66) begin
            errors++;
            $display("FAIL init_latency: got %0d cycles expected 64..66", n);
        end
        repeat (100 - n) step();
        chk("held.sel_valid", sel_valid, 0);
        mouse_left = 1'b0;
        model_reset();
        step();
        check_en = 1;
        sweep = 1;
        repeat (64) step();

        // Move 52 -> 36 with a continuous read sweep running.
        click(TX0 + 4 * SQ + 5, TY0 + 6 * SQ + 5, 4);
        chk_state("sel52");
        chk("sel52.sel_xy", sel_xy, 52);
        click(TX0 + 4 * SQ + 5, TY0 + 4 * SQ + 5, 4);
        chk_state("move52_36");
        repeat (64) step();
        sweep = 0;

        click(px(3), py(3), 4);
        chk_state("empty27");
        click(255, py(6), 4);
        chk_state("x255");
        click(768, py(6), 4);
        chk_state("x768");
        click(px(0), 640, 4);
        chk_state("y640");
        click(px(0), 127, 4);
        chk_state("y127");
        click(256, py(6), 4);
        chk_state("x256");
        click(256, py(6), 4);
        chk_state("x256_desel");
        click(767, py(6), 4);
        chk_state("x767");
        click(767, py(6), 4);
        chk_state("x767_desel");

        click(px(2), py(6), 4);
        chk_state("sel50");
        click(px(2), py(6), 4);
        chk_state("desel50");

        // Second move, then a press while the move is still being written.
        click(px(3), py(6), 4);
        click(px(3), py(5), 1);
        click(px(2), py(6), 4);
        chk_state("drop_busy");
        click(px(1), py(6), 4);
        click(px(1), py(5), 4);
        chk_state("move49_41");

        sweep = 1;
        for (int i = 0; i < 80; i++) begin
            click(int'($urandom_range(200, 830)), int'($urandom_range(90, 700)),
                  int'($urandom_range(3, 6)));
            chk_state("rand");
        end
        sweep = 0;

        // Select a piece, then board_reset together with a press.
        n = 0;
        while (mboard[n] == 4'd0) n++;
        click(px(n % 8), py(n / 8), 4);
        chk_state("presel");
        xpos = 12'(px(4));
        ypos = 12'(py(4));
        mouse_left = 1'b1;
        board_reset = 1'b1;
        step();
        board_reset = 1'b0;
        mouse_left = 1'b0;
        check_en = 0;
        model_reset();
        chk("brst.sel_valid", sel_valid, 0);
        chk("brst.init_done", init_done, 0);
        chk("brst.move_cnt", move_cnt, 0);
        wait_init("brst");
        step();
        check_en = 1;
        sweep = 1;
        repeat (64) step();
        chk_state("after_brst");

        check_en = 0;
        step();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_ctl.md
BOARD_CTL -- requirements
Module: board_ctl

Interface
REQ-001 The block SHALL provide parameter BOARD_X0, default 256, meaning the left pixel column of the 8x8 board.
REQ-002 The block SHALL provide parameter BOARD_Y0, default 128, meaning the top pixel row of the board.
REQ-003 The block SHALL provide parameter SQ_LOG2, default 6, meaning log2 of the square edge in pixels; the board spans 8<<SQ_LOG2 pixels per side.
REQ-004 clk  input  1  single system clock; the block uses no other clock.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 mouse_left  input  1  left button level, already synchronous to clk.
REQ-007 xpos  input  12  mouse x pixel, synchronous to clk.
REQ-008 ypos  input  12  mouse y pixel, synchronous to clk.
REQ-009 board_reset  input  1  synchronous one-cycle request to restore the start position.
REQ-010 figure_xy  input  6  draw-side read address {row[2:0], col[2:0]}.
REQ-011 figure_code  output  4  registered board content at figure_xy.
REQ-012 sel_valid  output  1  a square is currently selected.
REQ-013 sel_xy  output  6  selected square address.
REQ-014 init_done  output  1  board contents valid.
REQ-015 move_cnt  output  8  completed moves count.

Function
REQ-016 Board storage SHALL be 64 entries x 4 bits: code 0 empty, 1-6 white pawn/knight/bishop/rook/queen/king, 9-14 black in the same order.
REQ-017 The read port SHALL return figure_code = board[figure_xy] exactly one clk after figure_xy is presented, in every state, with no stall.
REQ-018 Controller writes SHALL use a separate write port; a read and a write to the same address in one cycle SHALL return the old content.
REQ-019 The block SHALL detect a press as a rising edge of mouse_left (registered previous level); held levels SHALL NOT generate further presses.
REQ-020 A press SHALL be in-board when BOARD_X0 <= xpos < BOARD_X0+(8<<SQ_LOG2) and BOARD_Y0 <= ypos < BOARD_Y0+(8<<SQ_LOG2), using 13-bit unsigned arithmetic with no wrap-around.
REQ-021 The clicked square SHALL be col = (xpos-BOARD_X0)>>SQ_LOG2 and row = (ypos-BOARD_Y0)>>SQ_LOG2, taking 3 bits each.
REQ-022 The FSM SHALL have the states INIT, IDLE, CHECK, SELECTED, WR_DST, WR_SRC.
REQ-023 INIT: a 6-bit counter SHALL write the start position for addresses 0..63, one entry per cycle. Rows 0/1 are black back rank R N B Q K B N R and black pawns. Rows 6/7 are white pawns and the white back rank. Rows 2-5 are 0. After address 63 the FSM SHALL set init_done=1 and enter IDLE.
REQ-024 IDLE: an in-board press SHALL latch the square and enter CHECK; out-of-board presses SHALL be ignored.
REQ-025 CHECK: the FSM SHALL read the latched square's code. If non-zero, it SHALL set sel_xy to the square, set sel_valid=1, and enter SELECTED. If zero, it SHALL return to IDLE.
REQ-026 SELECTED: a press on the same square SHALL clear sel_valid and enter IDLE. A press on another in-board square SHALL enter WR_DST. Out-of-board presses SHALL be ignored.
REQ-027 WR_DST SHALL write board[dst] = board[sel_xy], overwriting any capture, then enter WR_SRC.
REQ-028 WR_SRC SHALL write board[sel_xy] = 0, clear sel_valid, increment move_cnt (wrapping 255->0), and enter IDLE.
REQ-029 Presses arriving during INIT, CHECK, WR_DST or WR_SRC SHALL be dropped, not queued.
REQ-030 board_reset in any state SHALL clear sel_valid and init_done, zero the INIT counter, and enter INIT next cycle; board_reset during INIT SHALL restart the fill from address 0. move_cnt SHALL be cleared.
REQ-031 board_reset and a press in the same cycle SHALL give board_reset priority.

Reset
REQ-032 Asserting rst low SHALL asynchronously force: state INIT, INIT counter 0, init_done 0, sel_valid 0, sel_xy 0, move_cnt 0, figure_code 0, and the edge-detect register 1 so a button held through reset is not seen as a press.
REQ-033 Board storage SHALL NOT require reset; its contents SHALL become valid through the INIT fill after rst deasserts.

Verification
REQ-034 Release rst -> init_done rises 64..66 cycles later. board[0]=4, board[4]=14... correction: board[0]=12, board[4]=14, board[8]=9, board[48]=1, board[60]=6, board[20]=0.
REQ-035 Defaults; press at (256+64*4+5, 128+64*6+5), then press at (256+64*4+5, 128+64*4+5) -> sel_xy=52 after the first press; after the second, board[36]=1, board[52]=0, move_cnt=1, sel_valid=0.
REQ-036 Press on empty square 27 -> sel_valid stays 0; press at xpos=255 -> ignored; press at xpos=768 -> ignored.
REQ-037 Select square 52, then press 52 again -> sel_valid=0, board unchanged, move_cnt unchanged.
REQ-038 Hold mouse_left high across rst and 100 cycles -> no selection. Assert board_reset while SELECTED after 3 moves -> move_cnt=0, start position restored.
REQ-039 Sweep figure_xy 0..63 continuously during a move -> every figure_code equals the model board state one cycle earlier.
